mac_mdc_tcdm_responder: RTL

//  TCDM slave (responder) answering the hwpe_stream_intf_tcdm load/store requests issued by the
//  mac_mdc streamer's master ports. Models one 32-bit-wide, byte-enabled memory bank shared by NP ports.

---
 rtl/mac_mdc_tcdm_responder.sv | 118 +++++++++++
 1 files changed

// File: rtl/mac_mdc_tcdm_responder.sv
// Single-bank, byte-enabled TCDM responder shared by NP ports with round-robin grant
// and a fixed-latency, non-back-pressured response pipeline.
module mac_mdc_tcdm_responder #(
   parameter int unsigned NP    = 4,
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned LAT   = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             stall_i,
   input  logic [NP-1:0]    tcdm_req_i,
   output logic [NP-1:0]    tcdm_gnt_o,
   input  logic [NP*32-1:0] tcdm_add_i,
   input  logic [NP-1:0]    tcdm_wen_i,
   input  logic [NP*4-1:0]  tcdm_be_i,
   input  logic [NP*32-1:0] tcdm_data_i,
   output logic [NP*32-1:0] tcdm_r_data_o,
   output logic [NP-1:0]    tcdm_r_valid_o,
   output logic             addr_err_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = (NP > 1) ? $clog2(NP) : 1;

   logic [31:0]   mem [DEPTH];
   logic [PW-1:0] ptr;

   logic          hit;
   logic [PW-1:0] sel;
   logic [31:0]   add;
   logic          wen;
   logic [3:0]    be;
   logic [31:0]   wdata;
   int unsigned   k;
   logic [AW-1:0] word;
   logic          bad;

   logic          pv    [LAT];
   logic [PW-1:0] pport [LAT];
   logic [31:0]   pdata [LAT];

   // First requester at or after the pointer, scanning cyclically.
   always_comb begin
      tcdm_gnt_o = '0;
      hit        = 1'b0;
      sel        = '0;
      add        = '0;
      wen        = 1'b0;
      be         = '0;
      wdata      = '0;
      k          = 0;
      if (!(rst_i || clear_i || stall_i)) begin
         for (int unsigned i = 0; i < NP; i++) begin
            k = (32'(ptr) + i) % NP;
            if (!hit && tcdm_req_i[k]) begin
               hit           = 1'b1;
               tcdm_gnt_o[k] = 1'b1;
               sel           = PW'(k);
               add           = tcdm_add_i[k*32 +: 32];
               wen           = tcdm_wen_i[k];
               be            = tcdm_be_i[k*4 +: 4];
               wdata         = tcdm_data_i[k*32 +: 32];
            end
         end
      end
   end

   always_comb begin
      word = add[AW+1:2];
      bad  = (add[1:0] != 2'b00) || ((add >> (AW + 2)) != 32'd0);
   end

   always_ff @(posedge clk_i) begin
      if (hit && !wen) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) mem[word][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   // Slot 0 captures the pre-write bank word at the grant edge; later slots just delay it.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         ptr <= '0;
         for (int unsigned i = 0; i < LAT; i++) begin
            pv[i]    <= 1'b0;
            pport[i] <= '0;
            pdata[i] <= '0;
         end
      end else begin
         pv[0]    <= hit;
         pport[0] <= sel;
         pdata[0] <= (hit && wen) ? mem[word] : '0;
         for (int unsigned i = 1; i < LAT; i++) begin
            pv[i]    <= pv[i-1];
            pport[i] <= pport[i-1];
            pdata[i] <= pdata[i-1];
         end
         if (hit) ptr <= (sel == PW'(NP - 1)) ? '0 : sel + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) addr_err_o <= 1'b0;
      else if (hit && bad) addr_err_o <= 1'b1;
   end

   always_comb begin
      tcdm_r_valid_o = '0;
      tcdm_r_data_o  = '0;
      if (pv[LAT-1]) begin
         tcdm_r_valid_o[pport[LAT-1]]        = 1'b1;
         tcdm_r_data_o[32*pport[LAT-1] +: 32] = pdata[LAT-1];
      end
   end

endmodule
